// File: rtl/clk_tick_gen.sv
// clk_tick_gen
// Multi-channel clock-enable generator running entirely in the CLK_50M domain.
// Each channel divides the clock by a runtime divisor. It produces a one-cycle
// TICK enable and a 50%-duty SQ square wave. New divisors are adopted only at
// safe points (hold, idle or period boundary), so a running period is never cut
// short. A request made mid-period is parked in a shadow register until the
// period ends.

module clk_tick_gen #(
    parameter int          NCH      = 4,
    parameter int          WIDTH    = 16,
    parameter int unsigned DIV_INIT = 27
) (
    input  logic                 CLK_50M,
    input  logic                 RST,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH*WIDTH-1:0] DIV,
    input  logic [NCH-1:0]       LOAD,
    input  logic                 SYNC,
    output logic [NCH-1:0]       TICK,
    output logic [NCH-1:0]       SQ,
    output logic [NCH-1:0]       PEND
);

    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DIV_INIT);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    for (genvar k = 0; k < NCH; k++) begin : g_ch

        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] act;
        logic [WIDTH-1:0] shd;
        logic             tick_q;
        logic             sq_q;
        logic             pend_q;

        logic [WIDTH-1:0] div_k;
        logic             idle;
        logic             terminal;
        logic             load_now;

        assign div_k = DIV[k*WIDTH +: WIDTH];

        // A divisor of zero parks the channel.
        assign idle = (act == '0);

        // The terminal edge is the last count of the current period. It only
        // exists while the channel is running.
        assign terminal = EN[k] && !idle && (cnt == act - ONE);

        // A load can be applied straight away whenever it cannot truncate a
        // running period: the channel is frozen, idle, or the period is ending.
        assign load_now = !EN[k] || idle || terminal;

        // Per-channel counter, divisor bookkeeping and registered outputs.
        always_ff @(posedge CLK_50M) begin
            if (RST) begin
                cnt    <= '0;
                act    <= DIV_RESET;
                shd    <= DIV_RESET;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
                pend_q <= 1'b0;
            end else if (SYNC) begin
                cnt    <= '0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
                pend_q <= 1'b0;
                if (LOAD[k]) begin
                    act <= div_k;
                end else if (pend_q) begin
                    act <= shd;
                end
            end else begin
                if (idle) begin
                    cnt    <= '0;
                    tick_q <= 1'b0;
                end else if (!EN[k]) begin
                    tick_q <= 1'b0;
                end else if (terminal) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    sq_q   <= ~sq_q;
                end else begin
                    cnt    <= cnt + ONE;
                    tick_q <= 1'b0;
                end

                if (LOAD[k]) begin
                    if (load_now) begin
                        act    <= div_k;
                        pend_q <= 1'b0;
                    end else begin
                        shd    <= div_k;
                        pend_q <= 1'b1;
                    end
                end else if (pend_q && terminal) begin
                    act    <= shd;
                    pend_q <= 1'b0;
                end
            end
        end

        assign TICK[k] = tick_q;
        assign SQ[k]   = sq_q;
        assign PEND[k] = pend_q;

    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen
// Directed testbench for clk_tick_gen with four 16-bit channels. Every expected
// value below is worked out by hand from edge numbers counted after each setup
// step.

module tb_clk_tick_gen;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;

    logic                 CLK_50M = 1'b0;
    logic                 RST     = 1'b1;
    logic                 SYNC    = 1'b0;
    logic [NCH-1:0]       EN      = '0;
    logic [NCH-1:0]       LOAD    = '0;
    logic [NCH*WIDTH-1:0] DIV     = '0;
    logic [NCH-1:0]       TICK;
    logic [NCH-1:0]       SQ;
    logic [NCH-1:0]       PEND;

    int tests_run    = 0;
    int tests_failed = 0;

    clk_tick_gen #(
        .NCH      (NCH),
        .WIDTH    (WIDTH),
        .DIV_INIT (27)
    ) dut (
        .CLK_50M (CLK_50M),
        .RST     (RST),
        .EN      (EN),
        .DIV     (DIV),
        .LOAD    (LOAD),
        .SYNC    (SYNC),
        .TICK    (TICK),
        .SQ      (SQ),
        .PEND    (PEND)
    );

    // 10-unit clock period.
    always #5 CLK_50M = ~CLK_50M;

    // Safety net in case the run ever stops advancing.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one set of inputs, let one rising edge consume them, then settle.
    task automatic applyStimulus(input logic rst, input logic sync,
                                 input logic [NCH-1:0] en, input logic [NCH-1:0] load,
                                 input logic [NCH*WIDTH-1:0] div);
        RST  = rst;
        SYNC = sync;
        EN   = en;
        LOAD = load;
        DIV  = div;
        @(posedge CLK_50M);
        #1;
    endtask

    function automatic logic [NCH*WIDTH-1:0] all_div(input logic [WIDTH-1:0] d);
        return {NCH{d}};
    endfunction

    initial begin
        logic [3:0] exp_tick;
        logic [3:0] exp_sq;
        logic [3:0] exp_pend;
        logic       t0;
        int         ticks0;

        // Reset defaults: every channel divides by 27.
        repeat (3) applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, '0);
        checkOutput("reset tick", TICK, 4'h0);
        checkOutput("reset sq", SQ, 4'h0);
        checkOutput("reset pend", PEND, 4'h0);
        for (int e = 1; e <= 60; e++) begin
            applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, '0);
            exp_tick = (e == 27 || e == 54) ? 4'hF : 4'h0;
            exp_sq   = (e >= 27 && e < 54) ? 4'hF : 4'h0;
            checkOutput($sformatf("default tick e%0d", e), TICK, exp_tick);
            checkOutput($sformatf("default sq e%0d", e), SQ, exp_sq);
        end

        // Deferred load: ch0 at D=10 gets D=4 while cnt=4.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'b0001, 64'd10);
        ticks0 = 0;
        for (int e = 1; e <= 30; e++) begin
            applyStimulus(1'b0, 1'b0, 4'hF, (e == 5) ? 4'b0001 : 4'b0000, 64'd4);
            t0       = (e == 10) || (e > 10 && (e - 10) % 4 == 0);
            ticks0   = ticks0 + (t0 ? 1 : 0);
            exp_tick = {(e == 27) ? 3'b111 : 3'b000, t0};
            exp_sq   = {(e >= 27) ? 3'b111 : 3'b000, ticks0[0]};
            exp_pend = (e >= 5 && e <= 9) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("deferred tick e%0d", e), TICK, exp_tick);
            checkOutput($sformatf("deferred sq e%0d", e), SQ, exp_sq);
            checkOutput($sformatf("deferred pend e%0d", e), PEND, exp_pend);
        end

        // Load arriving on the terminal edge: 5 -> 3 applies at once.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'b0001, 64'd5);
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(1'b0, 1'b0, 4'b0001, (e == 5) ? 4'b0001 : 4'b0000, 64'd3);
            exp_tick = (e == 5 || e == 8 || e == 11) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("term load tick e%0d", e), TICK, exp_tick);
            checkOutput($sformatf("term load pend e%0d", e), PEND, 4'h0);
        end

        // Two loads while pending: 7 then 9, the later one wins.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'b0001, 64'd10);
        for (int e = 1; e <= 30; e++) begin
            applyStimulus(1'b0, 1'b0, 4'b0001, (e == 3 || e == 4) ? 4'b0001 : 4'b0000,
                          (e == 3) ? 64'd7 : 64'd9);
            exp_tick = (e == 10 || e == 19 || e == 28) ? 4'b0001 : 4'b0000;
            exp_pend = (e >= 3 && e <= 9) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("double load tick e%0d", e), TICK, exp_tick);
            checkOutput($sformatf("double load pend e%0d", e), PEND, exp_pend);
        end

        // Enable freeze: D=8, one full period, stop at cnt=5 for 20 cycles.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'b0001, 64'd8);
        for (int e = 1; e <= 13; e++) begin
            applyStimulus(1'b0, 1'b0, 4'b0001, 4'h0, '0);
            checkOutput($sformatf("freeze pre tick e%0d", e), TICK, (e == 8) ? 4'b0001 : 4'b0000);
        end
        checkOutput("freeze pre sq", SQ, 4'b0001);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, '0);
            checkOutput($sformatf("frozen tick i%0d", i), TICK, 4'h0);
            checkOutput($sformatf("frozen sq i%0d", i), SQ, 4'b0001);
        end
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(1'b0, 1'b0, 4'b0001, 4'h0, '0);
            checkOutput($sformatf("resume tick r%0d", r), TICK, (r == 3) ? 4'b0001 : 4'b0000);
            checkOutput($sformatf("resume sq r%0d", r), SQ, (r == 3) ? 4'b0000 : 4'b0001);
        end

        // SYNC realignment of staggered channels, all at D=6.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, all_div(16'd6));
        applyStimulus(1'b0, 1'b0, 4'b0001, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'b0011, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'b0111, 4'h0, '0);
        repeat (4) applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, '0);
        checkOutput("pre sync sq0", {31'd0, SQ[0]}, 32'd1);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, '0);
        checkOutput("sync tick", TICK, 4'h0);
        checkOutput("sync sq", SQ, 4'h0);
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, '0);
            checkOutput($sformatf("aligned tick e%0d", e), TICK, (e % 6 == 0) ? 4'hF : 4'h0);
            checkOutput($sformatf("aligned sq e%0d", e), SQ, (e >= 6 && e < 12) ? 4'hF : 4'h0);
        end

        // SYNC together with LOAD[1]=2.
        applyStimulus(1'b0, 1'b1, 4'hF, 4'b0010, all_div(16'd2));
        checkOutput("sync load tick", TICK, 4'h0);
        checkOutput("sync load sq", SQ, 4'h0);
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, '0);
            exp_tick = (e % 6 == 0) ? 4'b1101 : 4'b0000;
            exp_tick[1] = (e % 2 == 0);
            checkOutput($sformatf("sync load tick e%0d", e), TICK, exp_tick);
        end

        // D=1: tick every cycle, SQ toggles every cycle.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'b0001, 64'd1);
        for (int e = 1; e <= 6; e++) begin
            applyStimulus(1'b0, 1'b0, 4'b0001, 4'h0, '0);
            checkOutput($sformatf("div1 tick e%0d", e), TICK, 4'b0001);
            checkOutput($sformatf("div1 sq e%0d", e), SQ, (e % 2 == 1) ? 4'b0001 : 4'b0000);
        end

        // LOAD 0 on that terminal edge: last tick toggles SQ to 1, then idle.
        applyStimulus(1'b0, 1'b0, 4'b0001, 4'b0001, 64'd0);
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(1'b0, 1'b0, 4'b0001, 4'h0, '0);
            checkOutput($sformatf("div0 tick e%0d", e), TICK, 4'h0);
            checkOutput($sformatf("div0 sq e%0d", e), SQ, 4'b0001);
        end

        // LOAD 65535 from idle, then watch the first tick at edge 65535.
        applyStimulus(1'b0, 1'b0, 4'hF, 4'b0001, 64'hFFFF);
        for (int e = 1; e <= 65535; e++) begin
            applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, '0);
            if (e == 1000 || e == 65534) begin
                checkOutput($sformatf("max div tick0 e%0d", e), {31'd0, TICK[0]}, 32'd0);
            end
            if (e == 65535) begin
                checkOutput("max div tick0 final", {31'd0, TICK[0]}, 32'd1);
                checkOutput("max div sq0 final", {31'd0, SQ[0]}, 32'd0);
            end
        end

        // Deferred load then reset mid-period: everything clears next cycle.
        applyStimulus(1'b0, 1'b0, 4'hF, 4'b0001, 64'd5);
        checkOutput("pre reset pend", PEND, 4'b0001);
        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, '0);
        checkOutput("mid reset tick", TICK, 4'h0);
        checkOutput("mid reset sq", SQ, 4'h0);
        checkOutput("mid reset pend", PEND, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
